xy_debounce: RTL and testbench
==============================

# xy_debounce

Two-channel input conditioner placed directly upstream of the x/y Moore state machine. It synchronises two raw asynchronous inputs (pushbuttons or switches), debounces each one independently, and drives clean level signals `x` and `y` straight into the FSM's `x`/`y` inputs. It also produces single-cycle rise and fall strobes for each channel, used for event counting and debug LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive synchronised samples needed to accept a new level (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- `CNT_W`, default 20: width of each channel's stability counter.

- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `x_raw`  in  1  asynchronous raw input, channel X.
- `y_raw`  in  1  asynchronous raw input, channel Y.
- `x`  out  1  debounced level, channel X; registered.
- `y`  out  1  debounced level, channel Y; registered.
- `x_rise`, `x_fall`  out  1 each  one-cycle strobes on accepted X transitions; registered.
- `y_rise`, `y_fall`  out  1 each  one-cycle strobes on accepted Y transitions; registered.

## Operation
- Each channel is an identical, independent instance of the same logic. Both channels can transition in the same cycle, and neither affects the other.
- Synchroniser: two flops, raw to s1 to s2. Only s2 feeds the channel FSM.
- Channel FSM has four states:
  - STABLE_LO: output 0. If s2=1, go to PEND_HI with cnt<=1. Otherwise stay, with cnt<=0.
  - PEND_HI: output 0.
    - If s2=0, go to STABLE_LO with cnt<=0. This is a glitch; it is rejected and no strobe is produced.
    - If s2=1 and cnt==DEBOUNCE_CYCLES-1, go to STABLE_HI, set output<=1, pulse rise<=1, and set cnt<=0.
    - Otherwise, cnt<=cnt+1.
  - STABLE_HI: mirror of STABLE_LO. If s2=0, go to PEND_LO with cnt<=1.
  - PEND_LO: mirror of PEND_HI. It completes to STABLE_LO with output<=0 and fall<=1.
- Strobes default to 0 every cycle. Each strobe is asserted only in the cycle right after the edge where the output changed, so it coincides with the first cycle of the new level.
- A rise strobe and a fall strobe on the same channel can never be asserted in the same cycle.
- Counter arithmetic is unsigned, CNT_W bits. The counter is always cleared on returning to a STABLE state, so it never wraps.
- Unreachable state encodings recover to STABLE_LO with output 0 on the next edge.

## Timing
- Reset, sampled at any rising edge while `reset`=1: s1, s2, cnt, and all outputs go to 0, and both FSMs go to STABLE_LO. Reset overrides every other transition, including a pending transition mid-count.
- If a raw input is held high through reset, it is requalified from scratch after reset: there is no shortcut and no strobe until the full latency has elapsed.
- Acceptance latency: raw level first sampled into s1 at edge E0 and held stable means the output changes immediately after edge E0+DEBOUNCE_CYCLES+1, with its strobe in that same cycle.
- Glitch rejection: if the s2 level reverts before DEBOUNCE_CYCLES consecutive samples of the new level, the output never changes.
- A pulse of exactly DEBOUNCE_CYCLES samples is accepted. A pulse of DEBOUNCE_CYCLES-1 samples is rejected.
- Because the counter restarts after each accepted transition, back-to-back accepted transitions are at least DEBOUNCE_CYCLES cycles apart.

## Test plan
Every scenario below uses DEBOUNCE_CYCLES=4 and CNT_W=3.

- Reset, then `x_raw`=1 first sampled at E0 and held -> `x`=0 through edge E4; `x`=1 and `x_rise`=1 after E5; `x_rise`=0 after E6. `y`, `y_rise` and `y_fall` stay 0 throughout.
- `x_raw` high for exactly 3 sampled cycles, then low -> `x` stays 0 and `x_rise` never asserts. Repeat with 4 sampled cycles -> `x` rises once, then falls after a further 5 edges, with one `x_fall` pulse.
- Bounce: `x_raw` toggles 1,0,1,0,1 per cycle, then holds 1 -> exactly one `x_rise`, 5 edges after the final 0 to 1 sample.
- `x_raw` and `y_raw` rise on the same edge -> `x` and `y` rise in the same cycle, and `x_rise` and `y_rise` assert together. Then only `y_raw` drops -> `y_fall` only, and `x` is unaffected.
- `reset` asserted for 1 cycle while channel X is in PEND_HI with cnt=2 and `x_raw` still 1 -> all outputs are 0 after the reset edge; `x` rises 6 edges after reset deasserts (2-flop synchroniser refill plus 4 samples).
- `x_raw` held 1 through reset -> no `x_rise` and `x`=0 until the full latency elapses after reset release.

Source files
------------

// File: rtl/xy_debounce.sv
// xy_debounce
// Two-channel input conditioner feeding the x/y Moore FSM. Each raw input
// is synchronised through two flops and then debounced by its own
// four-state qualifier. A new level is accepted only after DEBOUNCE_CYCLES
// consecutive synchronised samples. A one-cycle rise or fall strobe marks
// the first cycle of each accepted level.
//
// Ports
//   clk              system clock, all logic on rising edge
//   reset            synchronous active-high reset
//   x_raw, y_raw     asynchronous raw inputs
//   x, y             debounced levels (registered)
//   x_rise, x_fall   one-cycle strobes on accepted X transitions (registered)
//   y_rise, y_fall   one-cycle strobes on accepted Y transitions (registered)

module xy_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The qualifying sample is the DEBOUNCE_CYCLES-th one, counted from 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Qualifier next-state, counter, level and strobe logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                lvl_d = 1'b0;
                if (s2_q) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            PEND_HI: begin
                lvl_d = 1'b0;
                if (!s2_q) begin
                    // Glitch: drop back without any strobe.
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                    lvl_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                lvl_d = 1'b1;
                if (!s2_q) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            PEND_LO: begin
                lvl_d = 1'b1;
                if (s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                    lvl_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Corrupted state register: recover to a known low level.
                state_d = STABLE_LO;
                cnt_d   = CNT_ZERO;
                lvl_d   = 1'b0;
            end
        endcase
    end

    // Qualifier state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

module xy_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic x_raw,
    input  logic y_raw,
    output logic x,
    output logic y,
    output logic x_rise,
    output logic x_fall,
    output logic y_rise,
    output logic y_fall
);

    xy_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_x (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (x_raw),
        .lvl_o  (x),
        .rise_o (x_rise),
        .fall_o (x_fall)
    );

    xy_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_y (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (y_raw),
        .lvl_o  (y),
        .rise_o (y_rise),
        .fall_o (y_fall)
    );

endmodule

// File: tb/tb_xy_debounce.sv
// tb_xy_debounce
// Directed bench for xy_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// Outputs are packed as {x, y, x_rise, x_fall, y_rise, y_fall} and checked
// 1 time unit after each rising edge against hand-computed vectors.

module tb_xy_debounce;

    logic       clk;
    logic       reset;
    logic       x_raw;
    logic       y_raw;
    logic       x;
    logic       y;
    logic       x_rise;
    logic       x_fall;
    logic       y_rise;
    logic       y_fall;
    logic [5:0] outs_s;

    int n_checks;
    int n_fail;

    xy_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .x_raw  (x_raw),
        .y_raw  (y_raw),
        .x      (x),
        .y      (y),
        .x_rise (x_rise),
        .x_fall (x_fall),
        .y_rise (y_rise),
        .y_fall (y_fall)
    );

    assign outs_s = {x, y, x_rise, x_fall, y_rise, y_fall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b expected %b (x y xr xf yr yf)", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled
    // at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        x_raw    = 1'b0;
        y_raw    = 1'b0;
        tick();
        tick();
        check_eq("reset", outs_s, 6'b000000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Basic acceptance latency: x_raw sampled at E0, x rises after E5.
        x_raw = 1'b1;
        tick();                                   // E0
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("lat_wait", outs_s, 6'b000000);
        end
        tick();                                   // E5
        check_eq("lat_rise", outs_s, 6'b101000);
        tick();                                   // E6
        check_eq("lat_hold", outs_s, 6'b100000);

        // Return to low and let everything settle.
        x_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("settle1", outs_s, 6'b000000);

        // Pulse of 3 samples: rejected.
        x_raw = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        x_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("pulse3", outs_s, 6'b000000);
        end

        // Pulse of 4 samples: accepted, then falls 5 edges after the low sample.
        x_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();       // E0..E3
        x_raw = 1'b0;
        tick();                                   // E4 samples low
        check_eq("pulse4_e4", outs_s, 6'b000000);
        tick();                                   // E5
        check_eq("pulse4_rise", outs_s, 6'b101000);
        for (int i = 6; i <= 8; i++) begin
            tick();
            check_eq("pulse4_hi", outs_s, 6'b100000);
        end
        tick();                                   // E9
        check_eq("pulse4_fall", outs_s, 6'b000100);
        tick();
        check_eq("pulse4_lo", outs_s, 6'b000000);
        for (int i = 0; i < 3; i++) tick();

        // Bounce 1,0,1,0,1 then hold 1: single rise 5 edges after last 0->1.
        for (int i = 0; i < 5; i++) begin
            x_raw = ((i % 2) == 0) ? 1'b1 : 1'b0;
            tick();
            check_eq("bounce_in", outs_s, 6'b000000);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("bounce_wait", outs_s, 6'b000000);
        end
        tick();
        check_eq("bounce_rise", outs_s, 6'b101000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bounce_hold", outs_s, 6'b100000);
        end
        x_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("settle2", outs_s, 6'b000000);

        // Both channels rise together, then only Y falls.
        x_raw = 1'b1;
        y_raw = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("both_wait", outs_s, 6'b000000);
        end
        tick();
        check_eq("both_rise", outs_s, 6'b111010);
        tick();
        check_eq("both_hold", outs_s, 6'b110000);
        y_raw = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("yfall_wait", outs_s, 6'b110000);
        end
        tick();
        check_eq("y_fall", outs_s, 6'b100001);
        tick();
        check_eq("y_low", outs_s, 6'b100000);
        x_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("settle3", outs_s, 6'b000000);

        // Reset while X is pending with cnt=2, x_raw stays high.
        x_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();       // E0..E3 -> PEND_HI cnt=2
        reset = 1'b1;
        tick();
        check_eq("rst_mid", outs_s, 6'b000000);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("rst_mid_wait", outs_s, 6'b000000);
        end
        tick();
        check_eq("rst_mid_rise", outs_s, 6'b101000);
        tick();
        check_eq("rst_mid_hold", outs_s, 6'b100000);

        // x_raw held high through a multi-cycle reset while x=1.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_held", outs_s, 6'b000000);
        end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("rst_held_wait", outs_s, 6'b000000);
        end
        tick();
        check_eq("rst_held_rise", outs_s, 6'b101000);
        tick();
        check_eq("rst_held_hold", outs_s, 6'b100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
